// File: rtl/div16by8_pkg.sv
// Shared widths, FSM encoding and result constants for the div16by8 signed divider.
package div16by8_pkg;

  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned Q_W   = 8;
  localparam int unsigned R_W   = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [Q_W-1:0] Q_POS_MAX = 8'h7F;
  localparam logic [Q_W-1:0] Q_NEG_MAX = 8'h80;

  // A signed 16-bit value fits in Q_W bits when its top DVD_W-Q_W+1 bits all agree.
  function automatic logic q_fits(input logic [DVD_W-1:0] v);
    logic [DVD_W-Q_W:0] top;
    top = v[DVD_W-1:Q_W-1];
    return (&top) | ~(|top);
  endfunction

endpackage

// File: rtl/div_abs_conv.sv
// Two's-complement <-> magnitude converter: negates the input when i_neg is set.
module div_abs_conv #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/div16by8.sv
// Sequential signed 16/8 restoring divider, one quotient bit per cycle, valid/ready both sides.
// Build option: define DIV16BY8_SAT_EN to saturate the quotient on overflow instead of wrapping.
module div16by8
  import div16by8_pkg::*;
(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   quotient,
  output logic [R_W-1:0]   remainder,
  output logic             ovf,
  output logic             dbz
);

  state_e             r_state;
  logic [DVD_W-1:0]   r_dvd;      // dividend magnitude, shifts into the quotient magnitude
  logic [DVS_W:0]     r_dvs;
  logic [DVS_W:0]     r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dvd_neg;
  logic               r_dvs_neg;
  logic               r_dbz;

  logic [Q_W-1:0]     r_quo;
  logic [R_W-1:0]     r_rmd;
  logic               r_ovf;
  logic               r_dbz_out;

  logic [DVD_W-1:0]   w_dvd_mag;
  logic [DVS_W:0]     w_dvs_mag;
  logic [DVD_W-1:0]   w_q_signed;
  logic [R_W-1:0]     w_r_signed;
  logic               w_q_neg;
  logic               w_accept;

  logic [DVS_W+1:0]   w_trial;
  logic [DVS_W+1:0]   w_diff;
  logic               w_ge;

  logic [Q_W-1:0]     w_quo;
  logic [R_W-1:0]     w_rmd;
  logic               w_ovf;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quo;
  assign remainder = r_rmd;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz_out;

  assign w_accept = in_valid && in_ready;
  assign w_q_neg  = r_dvd_neg ^ r_dvs_neg;

  div_abs_conv #(.W(DVD_W)) u_dvd_abs (
    .i_val (dividend),
    .i_neg (dividend[DVD_W-1]),
    .o_val (w_dvd_mag)
  );

  div_abs_conv #(.W(DVS_W + 1)) u_dvs_abs (
    .i_val ({divisor[DVS_W-1], divisor}),
    .i_neg (divisor[DVS_W-1]),
    .o_val (w_dvs_mag)
  );

  div_abs_conv #(.W(DVD_W)) u_quo_sign (
    .i_val (r_dvd),
    .i_neg (w_q_neg),
    .o_val (w_q_signed)
  );

  div_abs_conv #(.W(R_W)) u_rem_sign (
    .i_val (r_rem[R_W-1:0]),
    .i_neg (r_dvd_neg),
    .o_val (w_r_signed)
  );

  // Restoring step: bring in the next dividend bit, subtract if the divisor fits.
  assign w_trial = {r_rem, r_dvd[DVD_W-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[DVS_W+1];

  always_comb begin
    w_quo = w_q_signed[Q_W-1:0];
    w_rmd = w_r_signed;
    w_ovf = 1'b0;
    if (r_dbz) begin
      w_quo = r_dvd_neg ? Q_NEG_MAX : Q_POS_MAX;
      w_rmd = '0;
    end else begin
      w_ovf = ~q_fits(w_q_signed);
`ifdef DIV16BY8_SAT_EN
      if (w_ovf) begin
        w_quo = w_q_neg ? Q_NEG_MAX : Q_POS_MAX;
      end
`endif
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state   <= IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_dbz     <= 1'b0;
      r_quo     <= '0;
      r_rmd     <= '0;
      r_ovf     <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd     <= w_dvd_mag;
            r_dvs     <= w_dvs_mag;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dvd_neg <= dividend[DVD_W-1];
            r_dvs_neg <= divisor[DVS_W-1];
            r_dbz     <= (divisor == '0);
            r_state   <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[DVS_W:0] : w_trial[DVS_W:0];
          r_dvd <= {r_dvd[DVD_W-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {CNT_W{1'b1}}) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quo     <= w_quo;
          r_rmd     <= w_rmd;
          r_ovf     <= w_ovf;
          r_dbz_out <= r_dbz;
          r_state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16by8.sv
// Self-checking bench for div16by8: directed spec cases, random ops vs integer model, handshakes.
module tb_div16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

`ifdef DIV16BY8_SAT_EN
  localparam logic [7:0] QOV_POS = 8'h7F;
`else
  localparam logic [7:0] QOV_POS = 8'h00;
`endif

  always #5 clk = ~clk;

  div16by8 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dividend       (dividend),
    .divisor        (divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .quotient       (quotient),
    .remainder      (remainder),
    .ovf            (ovf),
    .dbz            (dbz)
  );

  // Reference: plain integer division (truncating, remainder takes the dividend's sign).
  task automatic model(input logic [15:0] a, input logic [7:0] b, output logic [7:0] q,
                       output logic [7:0] r, output logic ov, output logic dz);
    int sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = (sb == 0);
    ov = 1'b0;
    if (dz) begin
      q = (sa >= 0) ? 8'h7F : 8'h80;
      r = 8'h00;
    end else begin
      iq = sa / sb;
      ir = sa % sb;
      ov = (iq > 127) || (iq < -128);
      q  = iq[7:0];
      r  = ir[7:0];
`ifdef DIV16BY8_SAT_EN
      if (ov) q = (iq > 0) ? 8'h7F : 8'h80;
`endif
    end
  endtask

  // Runs one op with an immediate result handshake. Entered and left 1 time unit after a posedge.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output logic [7:0] q,
                       output logic [7:0] r, output logic ov, output logic dz, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL do_op_in_ready_wait got %b required 1", in_ready);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    q  = quotient;
    r  = remainder;
    ov = ovf;
    dz = dbz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    if (quotient !== 8'h00) begin errors++; $display("FAIL reset_quotient got %h required 00", quotient); end
    if (remainder !== 8'h00) begin errors++; $display("FAIL reset_remainder got %h required 00", remainder); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b required 0", ovf); end
    if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b required 0", dbz); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [8];
    logic [7:0]  tb [8];
    logic [7:0]  tq [8];
    logic [7:0]  tr [8];
    logic        tov [8];
    logic        tdz [8];
    logic [7:0]  q, r;
    logic        ov, dz;
    int          lat;
    ta  = '{16'd100, 16'hFF9C, 16'd100, 16'h7F01, 16'h8000, 16'd500, 16'hFE0C, 16'h8000};
    tb  = '{8'd7, 8'd7, 8'hF9, 8'd127, 8'h80, 8'h00, 8'h00, 8'hFF};
    tq  = '{8'h0E, 8'hF2, 8'hF2, QOV_POS, QOV_POS, 8'h7F, 8'h80, QOV_POS};
    tr  = '{8'h02, 8'hFE, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    tov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tdz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb[i], q, r, ov, dz, lat);
      checks += 5;
      if (q !== tq[i]) begin errors++; $display("FAIL dir%0d_quotient got %h required %h", i, q, tq[i]); end
      if (r !== tr[i]) begin errors++; $display("FAIL dir%0d_remainder got %h required %h", i, r, tr[i]); end
      if (ov !== tov[i]) begin errors++; $display("FAIL dir%0d_ovf got %b required %b", i, ov, tov[i]); end
      if (dz !== tdz[i]) begin errors++; $display("FAIL dir%0d_dbz got %b required %b", i, dz, tdz[i]); end
      if (lat != (tdz[i] ? 1 : 17)) begin
        errors++; $display("FAIL dir%0d_latency got %0d required %0d", i, lat, tdz[i] ? 1 : 17);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q0, r0, eq, er;
    logic       ov0, dz0, eov, edz;
    int         n;
    model(16'd1000, 8'hFD, eq, er, eov, edz);
    dividend = 16'd1000;
    divisor  = 8'hFD;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    q0 = quotient; r0 = remainder; ov0 = ovf; dz0 = dbz;
    checks += 4;
    if (q0 !== eq) begin errors++; $display("FAIL bp_quotient got %h required %h", q0, eq); end
    if (r0 !== er) begin errors++; $display("FAIL bp_remainder got %h required %h", r0, er); end
    if (ov0 !== eov) begin errors++; $display("FAIL bp_ovf got %b required %b", ov0, eov); end
    if (dz0 !== edz) begin errors++; $display("FAIL bp_dbz got %b required %b", dz0, edz); end
    // A second request arrives while the result is stalled; it must be ignored.
    dividend = 16'd77;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d got %b required 1", c, out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready c%0d got %b required 0", c, in_ready); end
      if ({quotient, remainder, ovf, dbz} !== {q0, r0, ov0, dz0}) begin
        errors++;
        $display("FAIL bp_hold_stable c%0d got %h/%h required %h/%h", c, quotient, remainder, q0, r0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after got %b required 0", out_valid); end
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL bp_ignored_op got %0d valid cycles required 0", n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r;
    logic       ov, dz;
    int         lat, n;
    dividend = 16'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b required 0", out_valid); end
    if ({quotient, remainder} !== 16'h0000) begin
      errors++; $display("FAIL rmid_outputs got %h/%h required 00/00", quotient, remainder);
    end
    if ({ovf, dbz} !== 2'b00) begin errors++; $display("FAIL rmid_flags got %b%b required 00", ovf, dbz); end
    n = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL rmid_no_valid got %0d valid cycles required 0", n); end
    do_op(16'd100, 8'd7, q, r, ov, dz, lat);
    checks += 3;
    if ({q, r} !== 16'h0E02) begin errors++; $display("FAIL rmid_next_result got %h/%h required 0e/02", q, r); end
    if ({ov, dz} !== 2'b00) begin errors++; $display("FAIL rmid_next_flags got %b%b required 00", ov, dz); end
    if (lat != 17) begin errors++; $display("FAIL rmid_next_latency got %0d required 17", lat); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  b, q, r, eq, er;
    logic        ov, dz, eov, edz;
    int          lat, sel;
    for (int i = 0; i < 40; i++) begin
      a   = 16'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 8'h00;
      else if (sel == 1) b = 8'($urandom_range(1, 3));
      else if (sel == 2) b = 8'h80;
      else b = 8'($urandom);
      model(a, b, eq, er, eov, edz);
      do_op(a, b, q, r, ov, dz, lat);
      checks += 5;
      if (q !== eq) begin errors++; $display("FAIL rnd_quotient %h/%h got %h required %h", a, b, q, eq); end
      if (r !== er) begin errors++; $display("FAIL rnd_remainder %h/%h got %h required %h", a, b, r, er); end
      if (ov !== eov) begin errors++; $display("FAIL rnd_ovf %h/%h got %b required %b", a, b, ov, eov); end
      if (dz !== edz) begin errors++; $display("FAIL rnd_dbz %h/%h got %b required %b", a, b, dz, edz); end
      if (lat != (edz ? 1 : 17)) begin
        errors++; $display("FAIL rnd_latency %h/%h got %0d required %0d", a, b, lat, edz ? 1 : 17);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eq_q[$], er_q[$];
    logic       eov_q[$], edz_q[$];
    int         acc[$];
    logic [7:0] q, r;
    logic       ov, dz;
    int         nacc;
    bit         took;
    nacc      = 0;
    out_ready = 1'b1;
    dividend  = 16'($urandom);
    divisor   = 8'($urandom_range(1, 255));
    in_valid  = 1'b1;
    for (int c = 0; c < 150 && (nacc < 4 || eq_q.size() > 0); c++) begin
      @(negedge clk);
      took = 1'b0;
      if (in_valid && in_ready) begin
        model(dividend, divisor, q, r, ov, dz);
        eq_q.push_back(q); er_q.push_back(r); eov_q.push_back(ov); edz_q.push_back(dz);
        acc.push_back(c);
        nacc++;
        took = 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (eq_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result got %h required none", quotient);
        end else begin
          if ({quotient, remainder, ovf, dbz} !== {eq_q[0], er_q[0], eov_q[0], edz_q[0]}) begin
            errors++;
            $display("FAIL b2b_result got %h/%h/%b/%b required %h/%h/%b/%b", quotient, remainder,
                     ovf, dbz, eq_q[0], er_q[0], eov_q[0], edz_q[0]);
          end
          void'(eq_q.pop_front()); void'(er_q.pop_front());
          void'(eov_q.pop_front()); void'(edz_q.pop_front());
        end
      end
      @(posedge clk); #1;
      if (took) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom_range(1, 255));
        if (nacc == 4) in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks += 2;
    if (nacc != 4) begin errors++; $display("FAIL b2b_accepts got %0d required 4", nacc); end
    if (eq_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d required 0", eq_q.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 19) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d required 19", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
